// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one single-ported memory between instruction fetch
// and data load/store, with a req/ready handshake, pipeline stall and watchdog abort.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifReq,
  input  logic [ADDR_W-1:0] ifAddr,
  output logic [DATA_W-1:0] ifData,
  output logic              ifDone,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [DATA_W-1:0] dWData,
  output logic [DATA_W-1:0] dRData,
  output logic              dDone,
  output logic              stall,
  output logic              mReq,
  output logic              mWe,
  output logic [ADDR_W-1:0] mAddr,
  output logic [DATA_W-1:0] mWData,
  input  logic [DATA_W-1:0] mRData,
  input  logic              mReady,
  output logic              errTimeout
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2
  } stateT;

  stateT             state, stateNext;
  logic              mReqNext, mWeNext;
  logic [ADDR_W-1:0] mAddrNext;
  logic [DATA_W-1:0] mWDataNext;
  logic              favorIf, favorIfNext;
  logic              errTimeoutNext;
  logic [CNT_W-1:0]  wdCnt, wdCntNext;
  logic              dReq;
  logic              finishing;

  assign dReq      = memRead | memWrite;
  // A busy transaction ends either on the memory handshake or on the watchdog limit.
  assign finishing = (state != IDLE) && (mReady || (wdCnt == WD_LAST));

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    stateNext      = state;
    mReqNext       = mReq;
    mWeNext        = mWe;
    mAddrNext      = mAddr;
    mWDataNext     = mWData;
    favorIfNext    = favorIf;
    errTimeoutNext = errTimeout;
    wdCntNext      = wdCnt;
    ifDone         = 1'b0;
    dDone          = 1'b0;
    ifData         = '0;
    dRData         = '0;

    case (state)
      IDLE: begin
        wdCntNext = '0;
        if (dReq && (!ifReq || !favorIf)) begin
          stateNext = D_BUSY;
          mReqNext  = 1'b1;
          mWeNext   = memWrite;
          mAddrNext = dAddr;
          if (memWrite) mWDataNext = dWData;
        end else if (ifReq) begin
          stateNext = IF_BUSY;
          mReqNext  = 1'b1;
          mWeNext   = 1'b0;
          mAddrNext = ifAddr;
        end
      end

      IF_BUSY, D_BUSY: begin
        if (finishing) begin
          if (state == IF_BUSY) begin
            ifDone = 1'b1;
            if (mReady) ifData = mRData;
          end else begin
            dDone = 1'b1;
            if (mReady && !mWe) dRData = mRData;
          end
          stateNext   = IDLE;
          mReqNext    = 1'b0;
          mWeNext     = 1'b0;
          wdCntNext   = '0;
          // Alternate priority after each completion so fetch cannot be starved.
          favorIfNext = (state == D_BUSY);
          if (!mReady) errTimeoutNext = 1'b1;
        end else begin
          wdCntNext = wdCnt + 1'b1;
        end
      end

      default: begin
        stateNext = IDLE;
        mReqNext  = 1'b0;
        mWeNext   = 1'b0;
      end
    endcase
  end

  assign stall = (dReq & ~dDone) | (ifReq & ~ifDone);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (rst) begin
      state      <= IDLE;
      mReq       <= 1'b0;
      mWe        <= 1'b0;
      mAddr      <= '0;
      mWData     <= '0;
      favorIf    <= 1'b0;
      errTimeout <= 1'b0;
      wdCnt      <= '0;
    end else begin
      state      <= stateNext;
      mReq       <= mReqNext;
      mWe        <= mWeNext;
      mAddr      <= mAddrNext;
      mWData     <= mWDataNext;
      favorIf    <= favorIfNext;
      errTimeout <= errTimeoutNext;
      wdCnt      <= wdCntNext;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level model checked every cycle,
// a scripted memory responder, and literal expectations for each scenario.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ifReq, memRead, memWrite, mReady;
  logic [AW-1:0] ifAddr, dAddr;
  logic [DW-1:0] dWData, mRData;
  logic [DW-1:0] ifData, dRData, mWData;
  logic [AW-1:0] mAddr;
  logic          ifDone, dDone, stall, mReq, mWe, errTimeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifData(ifData), .ifDone(ifDone),
    .memRead(memRead), .memWrite(memWrite), .dAddr(dAddr), .dWData(dWData),
    .dRData(dRData), .dDone(dDone), .stall(stall),
    .mReq(mReq), .mWe(mWe), .mAddr(mAddr), .mWData(mWData),
    .mRData(mRData), .mReady(mReady), .errTimeout(errTimeout)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h40:  memWord = 32'h8C01_0004;
      32'h44:  memWord = 32'h0022_1820;
      32'h100: memWord = 32'h1234_5678;
      default: memWord = a ^ 32'hA5A5_0000;
    endcase
  endfunction

  // Memory responder: answers after waitCycles wait states, garbage data otherwise.
  int waitCycles = 0;
  int reqAge = 0;
  initial begin
    mReady = 1'b0;
    mRData = '0;
  end
  always @(posedge clk) begin
    #1;
    if (mReq === 1'b1) begin
      if (reqAge >= waitCycles) begin
        mReady = 1'b1;
        mRData = memWord(mAddr);
      end else begin
        mReady = 1'b0;
        mRData = $urandom;
      end
      reqAge++;
    end else begin
      mReady = 1'b0;
      mRData = $urandom;
      reqAge = 0;
    end
  end

  // Transaction-level model: one outstanding transfer, alternating priority, watchdog.
  typedef struct {
    bit          active;
    bit          isFetch;
    bit          isStore;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          age;
  } txnT;

  txnT cur;
  bit  favor = 1'b0;
  bit  err   = 1'b0;
  bit  chk   = 1'b0;

  initial cur.active = 1'b0;

  always @(negedge clk) begin : mdl
    bit ending, served, dreq;
    dreq   = (memRead === 1'b1) || (memWrite === 1'b1);
    ending = cur.active && ((mReady === 1'b1) || (cur.age == TO - 1));
    served = cur.active && (mReady === 1'b1);
    if (chk) begin
      check("mReq", mReq, cur.active);
      check("mWe", mWe, cur.active && cur.isStore);
      if (cur.active) check("mAddr", mAddr, cur.addr);
      if (cur.active && cur.isStore) check("mWData", mWData, cur.wdata);
      check("ifDone", ifDone, ending && cur.isFetch);
      check("ifData", ifData, (served && cur.isFetch) ? memWord(cur.addr) : 32'h0);
      check("dDone", dDone, ending && !cur.isFetch);
      check("dRData", dRData, (served && !cur.isFetch && !cur.isStore) ? memWord(cur.addr) : 32'h0);
      check("stall", stall, (dreq && !(ending && !cur.isFetch)) || (ifReq && !(ending && cur.isFetch)));
      check("errTimeout", errTimeout, err);
    end
    if (rst) begin
      cur.active = 1'b0;
      favor      = 1'b0;
      err        = 1'b0;
    end else if (cur.active) begin
      if (ending) begin
        favor = !cur.isFetch;
        if (mReady !== 1'b1) err = 1'b1;
        cur.active = 1'b0;
      end else begin
        cur.age++;
      end
    end else if (dreq && (!ifReq || !favor)) begin
      cur.active  = 1'b1;
      cur.isFetch = 1'b0;
      cur.isStore = memWrite;
      cur.addr    = dAddr;
      cur.wdata   = dWData;
      cur.age     = 0;
    end else if (ifReq) begin
      cur.active  = 1'b1;
      cur.isFetch = 1'b1;
      cur.isStore = 1'b0;
      cur.addr    = ifAddr;
      cur.wdata   = '0;
      cur.age     = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called with a request just driven; returns at the negedge of the done cycle.
  task automatic waitDone(input bit wantIf, input int budget, output int cycles);
    bit found = 1'b0;
    cycles = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((wantIf ? ifDone : dDone) === 1'b1) begin
        cycles = i;
        found  = 1'b1;
        break;
      end
      tick();
    end
    if (!found) check("waitDone budget", 1'b0, 1'b1);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    byte order[$];
    logic [31:0] seenIf, seenD;
    int cnt, cyc;

    ifReq = 0; memRead = 0; memWrite = 0;
    ifAddr = '0; dAddr = '0; dWData = '0;

    // Reset state
    tick(); tick();
    chk = 1'b1;
    @(negedge clk);
    check("rst mReq", mReq, 1'b0);
    check("rst mAddr", mAddr, 32'h0);
    check("rst mWData", mWData, 32'h0);
    check("rst errTimeout", errTimeout, 1'b0);
    check("rst stall", stall, 1'b0);

    // Single fetch, one wait cycle
    tick();
    rst = 0; ifReq = 1; ifAddr = 32'h40; waitCycles = 1;
    @(negedge clk);
    check("fetch c0 stall", stall, 1'b1);
    check("fetch c0 mReq", mReq, 1'b0);
    tick();
    @(negedge clk);
    check("fetch c1 stall", stall, 1'b1);
    check("fetch c1 mAddr", mAddr, 32'h40);
    check("fetch c1 mWe", mWe, 1'b0);
    check("fetch c1 ifDone", ifDone, 1'b0);
    tick();
    @(negedge clk);
    check("fetch c2 ifDone", ifDone, 1'b1);
    check("fetch c2 ifData", ifData, 32'h8C01_0004);
    check("fetch c2 stall", stall, 1'b0);
    tick();
    ifReq = 0;
    tick();

    // Simultaneous requests from reset, zero-wait memory
    rst = 1; ifReq = 1; memRead = 1; dAddr = 32'h100; ifAddr = 32'h44; waitCycles = 0;
    tick(); tick();
    rst = 0;
    seenIf = '0; seenD = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (dDone === 1'b1) begin
        order.push_back("D");
        if (order.size() == 1) seenD = dRData;
      end
      if (ifDone === 1'b1) begin
        order.push_back("I");
        seenIf = ifData;
      end
      tick();
    end
    ifReq = 0; memRead = 0;
    check("arb count", order.size(), 3);
    if (order.size() == 3) begin
      check("arb first", order[0], "D");
      check("arb second", order[1], "I");
      check("arb third", order[2], "D");
    end
    check("arb dRData", seenD, 32'h1234_5678);
    check("arb ifData", seenIf, 32'h0022_1820);
    tick();

    // Store with three wait cycles
    memWrite = 1; dAddr = 32'h200; dWData = 32'hDEAD_BEEF; waitCycles = 3;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mReq === 1'b1) begin
        cnt++;
        check("store mWe", mWe, 1'b1);
        check("store mAddr", mAddr, 32'h200);
        check("store mWData", mWData, 32'hDEAD_BEEF);
      end
      if (dDone === 1'b1) begin
        check("store dRData", dRData, 32'h0);
        break;
      end
      tick();
    end
    check("store mReq cycles", cnt, 4);
    tick();
    memWrite = 0;
    tick();

    // Watchdog abort
    memRead = 1; dAddr = 32'h300; waitCycles = 1000;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mReq === 1'b1) cnt++;
      if (dDone === 1'b1) begin
        check("abort dRData", dRData, 32'h0);
        break;
      end
      tick();
    end
    check("abort mReq cycles", cnt, 4);
    tick();
    memRead = 0;
    @(negedge clk);
    check("abort errTimeout", errTimeout, 1'b1);
    tick(); tick();
    @(negedge clk);
    check("abort errTimeout sticky", errTimeout, 1'b1);

    // Load with two wait cycles
    tick();
    memRead = 1; dAddr = 32'h104; waitCycles = 2;
    waitDone(1'b0, 10, cyc);
    check("load latency", cyc, 3);
    check("load dRData", dRData, 32'hA5A5_0104);
    tick();
    memRead = 0;
    tick();

    // Reset on the second wait cycle of a fetch
    ifReq = 1; ifAddr = 32'h48; waitCycles = 5;
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0; ifReq = 0;
    @(negedge clk);
    check("rstmid mReq", mReq, 1'b0);
    check("rstmid ifDone", ifDone, 1'b0);
    check("rstmid stall", stall, 1'b0);
    check("rstmid errTimeout", errTimeout, 1'b0);
    tick();
    ifReq = 1; ifAddr = 32'h4C; waitCycles = 0;
    waitDone(1'b1, 6, cyc);
    check("rstmid refetch latency", cyc, 1);
    check("rstmid refetch ifData", ifData, 32'hA5A5_004C);
    tick();
    ifReq = 0;
    tick();

    // memRead and memWrite together behave as a store
    memRead = 1; memWrite = 1; dAddr = 32'h240; dWData = 32'h0BAD_F00D; waitCycles = 0;
    tick();
    @(negedge clk);
    check("rdwr mWe", mWe, 1'b1);
    check("rdwr mWData", mWData, 32'h0BAD_F00D);
    check("rdwr dDone", dDone, 1'b1);
    check("rdwr dRData", dRData, 32'h0);
    tick();
    memRead = 0; memWrite = 0;
    tick(); tick();

    chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
